// File: rtl/inst_fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
package inst_fetch_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [XLEN-1:0] INST_BYTES = 32'd4;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } fetch_entry_t;

  typedef enum logic {
    ST_RESET = 1'b0,
    ST_RUN   = 1'b1
  } fetch_state_e;

  // Clears the byte offset so redirect targets always land on a word.
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return addr & ~(XLEN'(3));
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous buffer of fetched {pc, inst} words; flush wins over push.
module fetch_fifo
  import inst_fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               push,
  input  logic               pop,
  input  logic               flush,
  input  fetch_entry_t       push_data,
  output logic [CNT_W-1:0]   count,
  output fetch_entry_t       head
);

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  // Storage is reset so the presented pc/inst read as zero out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      mem    <= '{default: '0};
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/inst_fetch.sv
// Fetch front end: issues ROM addresses, tags returning words with their PC,
// buffers them for decode and handles execute redirects.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rd_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_inst
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned OCC_W = CNT_W + 1;

  fetch_state_e     state_q;
  fetch_state_e     state_d;
  logic [31:0]      fetch_pc;
  logic [31:0]      inflight_pc;
  logic             inflight;
  logic [CNT_W-1:0] count;
  fetch_entry_t     head;
  fetch_entry_t     push_data_c;
  logic             issue_c;
  logic             push_c;
  logic             pop_c;
  logic [OCC_W-1:0] occ_c;

  assign out_valid = (count != '0);
  assign pop_c     = out_valid & out_ready;
  // Slots already claimed once this cycle's pop retires; issuing only below
  // depth guarantees a home for every returning word.
  assign occ_c     = OCC_W'(count) + OCC_W'(inflight) - OCC_W'(pop_c);
  assign push_data_c = '{pc: inflight_pc, inst: imem_rd_data};

  always_comb begin
    state_d   = state_q;
    issue_c   = 1'b0;
    imem_addr = fetch_pc;
    case (state_q)
      ST_RESET: state_d = ST_RUN;
      ST_RUN:   issue_c = (occ_c < OCC_W'(FIFO_DEPTH));
    endcase
    if (redirect_valid) begin
      issue_c   = 1'b1;
      imem_addr = word_align(redirect_pc);
    end
    push_c = inflight & ~redirect_valid;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_RESET;
      fetch_pc    <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else begin
      state_q <= state_d;
      if (issue_c) begin
        fetch_pc    <= imem_addr + INST_BYTES;
        inflight    <= 1'b1;
        inflight_pc <= imem_addr;
      end else begin
        inflight <= 1'b0;
      end
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push_c),
    .pop       (pop_c),
    .flush     (redirect_valid),
    .push_data (push_data_c),
    .count     (count),
    .head      (head)
  );

  assign out_pc   = head.pc;
  assign out_inst = head.inst;

endmodule
